// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit : fetch-stage program counter with trap/redirect/RAS next-PC select.
//
// Holds the fetch PC and picks the next PC each cycle from, in priority order:
// reset, trap, stall, redirect, return-address-stack prediction, sequential.
// Trap and redirect targets that are not instruction-aligned are rejected:
// the PC holds and a one-cycle misaligned pulse reports the offending target.
//
// Optional feature macro: PC_C_EXT_EN
//   defined   : 16-bit instructions supported, step_half selects a step of 2/4,
//               and only target bit 0 is checked for alignment.
//   undefined : step fixed at 4, step_half ignored, bits [1:0] checked.
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = {XLEN{1'b0}},
   parameter int                RAS_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          trap_valid,
   input  logic [XLEN-1:0]               trap_target,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_target,
   input  logic                          ras_push,
   input  logic                          ras_pop,
   input  logic                          step_half,
   output logic [XLEN-1:0]               pc,
   output logic [XLEN-1:0]               pc_plus,
   output logic                          misaligned,
   output logic [XLEN-1:0]               misaligned_addr,
   output logic [$clog2(RAS_DEPTH):0]    ras_count
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);
   localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   // Alignment rule for a trap/redirect target.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
`ifdef PC_C_EXT_EN
      return (addr[0] != 1'b0);
`else
      return (addr[1:0] != 2'b00);
`endif
   endfunction

   // Architectural state.
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_mis_addr;
   logic            r_mis;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_top;
   logic [XLEN-1:0] r_ras [RAS_DEPTH];

   // Next-state and RAS write controls.
   logic [XLEN-1:0] w_step;
   logic [XLEN-1:0] w_pc_plus;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_mis_addr_nxt;
   logic            w_mis_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [PW-1:0]   w_top_nxt;
   logic            w_pop_hit;
   logic            w_ras_we;
   logic [PW-1:0]   w_ras_waddr;
   logic [XLEN-1:0] w_ras_wdata;

`ifndef PC_C_EXT_EN
   // step_half has no meaning without 16-bit instruction support.
   logic w_unused_step_half;
   assign w_unused_step_half = step_half;
`endif

   // Sequential step size: 2 for a 16-bit instruction, otherwise 4.
   always_comb begin
`ifdef PC_C_EXT_EN
      if (step_half) begin
         w_step = XLEN'(2);
      end else begin
         w_step = XLEN'(4);
      end
`else
      w_step = XLEN'(4);
`endif
   end

   assign w_pc_plus = r_pc + w_step;

   // Next-PC selection, RAS bookkeeping and misalignment detection.
   always_comb begin
      w_pc_nxt       = r_pc;
      w_mis_addr_nxt = r_mis_addr;
      w_mis_nxt      = 1'b0;
      w_count_nxt    = r_count;
      w_top_nxt      = r_top;
      w_ras_we       = 1'b0;
      w_ras_waddr    = r_top;
      w_ras_wdata    = w_pc_plus;
      w_pop_hit      = ras_pop && (r_count != COUNT_ZERO);

      if (trap_valid) begin
         // Trap ignores stall and always flushes the return stack.
         w_count_nxt = COUNT_ZERO;
         if (is_misaligned(trap_target)) begin
            w_mis_nxt      = 1'b1;
            w_mis_addr_nxt = trap_target;
         end else begin
            w_pc_nxt = trap_target;
         end
      end else if (!enable) begin
         // Stall: everything holds, the misaligned pulse simply ends.
         w_pc_nxt = r_pc;
      end else if (redirect_valid) begin
         // Resolved redirect wins over any RAS activity this cycle.
         if (is_misaligned(redirect_target)) begin
            w_mis_nxt      = 1'b1;
            w_mis_addr_nxt = redirect_target;
         end else begin
            w_pc_nxt = redirect_target;
         end
      end else if (w_pop_hit && ras_push) begin
         // Return and call together: predict old top, replace it in place.
         w_pc_nxt    = r_ras[r_top];
         w_ras_we    = 1'b1;
         w_ras_waddr = r_top;
      end else if (w_pop_hit) begin
         w_pc_nxt    = r_ras[r_top];
         w_top_nxt   = r_top - PTR_ONE;
         w_count_nxt = r_count - COUNT_ONE;
      end else if (ras_push) begin
         // Circular push: when full, the oldest entry is overwritten.
         w_pc_nxt    = w_pc_plus;
         w_top_nxt   = r_top + PTR_ONE;
         w_ras_we    = 1'b1;
         w_ras_waddr = r_top + PTR_ONE;
         if (r_count == COUNT_FULL) begin
            w_count_nxt = r_count;
         end else begin
            w_count_nxt = r_count + COUNT_ONE;
         end
      end else begin
         // Sequential fetch, including a pop on an empty stack.
         w_pc_nxt = w_pc_plus;
      end
   end

   // PC, misalignment and RAS pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_VECTOR;
         r_mis      <= 1'b0;
         r_mis_addr <= {XLEN{1'b0}};
         r_count    <= COUNT_ZERO;
         r_top      <= {PW{1'b0}};
      end else begin
         r_pc       <= w_pc_nxt;
         r_mis      <= w_mis_nxt;
         r_mis_addr <= w_mis_addr_nxt;
         r_count    <= w_count_nxt;
         r_top      <= w_top_nxt;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (!reset && w_ras_we) begin
         r_ras[w_ras_waddr] <= w_ras_wdata;
      end
   end

   assign pc              = r_pc;
   assign pc_plus         = w_pc_plus;
   assign misaligned      = r_mis;
   assign misaligned_addr = r_mis_addr;
   assign ras_count       = r_count;

endmodule
